ras_ckpt: RTL and testbench

Parametrised circular return-address stack with single-level checkpoint/restore, for use by the fetch/decode branch predictor. Calls push their return address, returns pop it, and a mispredicted branch restores the stack to its state at prediction time, repairing one wrong-path overwrite. The stack overwrites its oldest entry instead of stalling when full.

---
 rtl/ras_ckpt.sv | 158 +++++++++++++++
 tb/tb_ras_ckpt.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ras_ckpt.sv
// ras_ckpt: circular return-address stack with a single-level checkpoint.
// Calls push pc+PUSH_OFFSET, returns pop, and a mispredict rolls the stack back
// to the snapshot, repairing one wrong-path overwrite of the snapshot's top.
// Full-stack pushes overwrite the oldest entry rather than stalling.
// Build option: define KRV_RAS_CKPT_EN to build the checkpoint logic; without it
// ckpt_save is ignored and ckpt_restore acts as flush.
module ras_ckpt #(
    parameter int unsigned ENTRY_NUM   = 16,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned PUSH_OFFSET = 4
) (
    input  logic                           cpu_clk,
    input  logic                           cpu_rst,
    input  logic                           push_vld,
    input  logic [ADDR_W-1:0]              push_pc,
    input  logic                           pop_vld,
    input  logic                           flush,
    input  logic                           ckpt_save,
    input  logic                           ckpt_restore,
    output logic                           top_vld,
    output logic [ADDR_W-1:0]              top_addr,
    output logic [$clog2(ENTRY_NUM):0]     count,
    output logic                           ovf_pulse,
    output logic                           udf_pulse
);

    localparam int unsigned IDX_W = $clog2(ENTRY_NUM);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [ADDR_W-1:0] mem_q [ENTRY_NUM];
    logic [IDX_W-1:0]  sp_q,  sp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [ADDR_W-1:0] push_addr;

    assign push_addr = push_pc + ADDR_W'(PUSH_OFFSET);

    // Next-state of the stack for this cycle's push/pop (ignoring flush/restore)
    always_comb begin
        sp_d   = sp_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = sp_q;
        ovf_d  = 1'b0;
        udf_d  = 1'b0;
        if (push_vld && pop_vld && (cnt_q != '0)) begin
            // tail call: replace the top in place
            wr_en  = 1'b1;
            wr_idx = sp_q - IDX_W'(1);
        end else if (push_vld) begin
            wr_en = 1'b1;
            sp_d  = sp_q + IDX_W'(1);
            if (cnt_q == CNT_W'(ENTRY_NUM)) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_vld) begin
            if (cnt_q != '0) begin
                sp_d  = sp_q - IDX_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                udf_d = 1'b1;
            end
        end
    end

`ifdef KRV_RAS_CKPT_EN
    logic              ckpt_vld_q;
    logic [IDX_W-1:0]  ckpt_sp_q;
    logic [CNT_W-1:0]  ckpt_cnt_q;
    logic [ADDR_W-1:0] ckpt_top_q;
    logic [ADDR_W-1:0] ckpt_top_c;
    logic [IDX_W-1:0]  top_idx_d;

    // Value that will sit at mem[sp_d-1] after this edge, including this cycle's write
    always_comb begin
        top_idx_d  = sp_d - IDX_W'(1);
        ckpt_top_c = mem_q[top_idx_d];
        if (wr_en && (wr_idx == top_idx_d)) begin
            ckpt_top_c = push_addr;
        end
    end
`else
    logic unused_ckpt_save;
    assign unused_ckpt_save = ckpt_save;
`endif

    // State update: reset > flush > restore > push/pop (+ save)
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            mem_q <= '{default: '0};
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
`ifdef KRV_RAS_CKPT_EN
            ckpt_vld_q <= 1'b0;
            ckpt_sp_q  <= '0;
            ckpt_cnt_q <= '0;
            ckpt_top_q <= '0;
`endif
        end else if (flush) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
`ifdef KRV_RAS_CKPT_EN
            ckpt_vld_q <= 1'b0;
`endif
        end else if (ckpt_restore) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
`ifdef KRV_RAS_CKPT_EN
            if (ckpt_vld_q) begin
                sp_q  <= ckpt_sp_q;
                cnt_q <= ckpt_cnt_q;
                if (ckpt_cnt_q != '0) begin
                    mem_q[ckpt_sp_q - IDX_W'(1)] <= ckpt_top_q;
                end
            end else begin
                sp_q  <= '0;
                cnt_q <= '0;
            end
            ckpt_vld_q <= 1'b0;
`else
            sp_q  <= '0;
            cnt_q <= '0;
`endif
        end else begin
            if (wr_en) begin
                mem_q[wr_idx] <= push_addr;
            end
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
`ifdef KRV_RAS_CKPT_EN
            if (ckpt_save) begin
                ckpt_vld_q <= 1'b1;
                ckpt_sp_q  <= sp_d;
                ckpt_cnt_q <= cnt_d;
                ckpt_top_q <= ckpt_top_c;
            end
`endif
        end
    end

    assign top_vld   = (cnt_q != '0);
    assign top_addr  = mem_q[sp_q - IDX_W'(1)];
    assign count     = cnt_q;
    assign ovf_pulse = ovf_q;
    assign udf_pulse = udf_q;

endmodule

// File: tb/tb_ras_ckpt.sv
// tb_ras_ckpt: directed vectors for ras_ckpt (ENTRY_NUM=4); a driver queues the
// expected post-edge outputs of each cycle and a monitor compares them after the edge.
module tb_ras_ckpt;

    localparam int unsigned EN = 4;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst, push_vld, pop_vld, flush, ckpt_save, ckpt_restore;
    logic [AW-1:0] push_pc;
    logic          top_vld, ovf_pulse, udf_pulse;
    logic [AW-1:0] top_addr;
    logic [2:0]    count;

    typedef struct {
        int          id;
        logic        vld;
        logic [31:0] addr;
        logic [2:0]  cnt;
        logic        ovf;
        logic        udf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    ras_ckpt #(.ENTRY_NUM(EN), .ADDR_W(AW), .PUSH_OFFSET(4)) dut (
        .cpu_clk(clk), .cpu_rst(rst), .push_vld(push_vld), .push_pc(push_pc),
        .pop_vld(pop_vld), .flush(flush), .ckpt_save(ckpt_save),
        .ckpt_restore(ckpt_restore), .top_vld(top_vld), .top_addr(top_addr),
        .count(count), .ovf_pulse(ovf_pulse), .udf_pulse(udf_pulse)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic step(input logic r, input logic pu, input logic [31:0] pc, input logic po,
                        input logic fl, input logic sv, input logic rs,
                        input logic ev, input logic [31:0] ea, input logic [2:0] ec,
                        input logic eo, input logic eu);
        exp_t e;
        @(negedge clk);
        rst = r; push_vld = pu; push_pc = pc; pop_vld = po;
        flush = fl; ckpt_save = sv; ckpt_restore = rs;
        e.id = vec_id; e.vld = ev; e.addr = ea; e.cnt = ec; e.ovf = eo; e.udf = eu;
        exp_q.push_back(e);
        vec_id++;
    endtask

    task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", id, name, act, want);
        end
    endtask

    // Monitor: compare queued expectations just after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.id, "top_vld",   32'(top_vld),   32'(e.vld));
                chk(e.id, "top_addr",  top_addr,       e.addr);
                chk(e.id, "count",     32'(count),     32'(e.cnt));
                chk(e.id, "ovf_pulse", 32'(ovf_pulse), 32'(e.ovf));
                chk(e.id, "udf_pulse", 32'(udf_pulse), 32'(e.udf));
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; push_vld = 1'b0; push_pc = '0; pop_vld = 1'b0;
        flush = 1'b0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
        //   rst pu pc        po fl sv rs   vld addr      cnt ovf udf
        step(1, 0, 32'h0,     0, 0, 0, 0,   0, 32'h0,     0, 0, 0);
        step(1, 0, 32'h0,     0, 0, 0, 0,   0, 32'h0,     0, 0, 0);
        // basic push/pop
        step(0, 1, 32'h100,   0, 0, 0, 0,   1, 32'h104,   1, 0, 0);
        step(0, 1, 32'h200,   0, 0, 0, 0,   1, 32'h204,   2, 0, 0);
        step(0, 1, 32'h300,   0, 0, 0, 0,   1, 32'h304,   3, 0, 0);
        step(0, 0, 32'h0,     1, 0, 0, 0,   1, 32'h204,   2, 0, 0);
        step(0, 0, 32'h0,     1, 0, 0, 0,   1, 32'h104,   1, 0, 0);
        // tail call on non-empty stack replaces top
        step(0, 1, 32'h500,   1, 0, 0, 0,   1, 32'h504,   1, 0, 0);
        // overflow wrap
        step(0, 0, 32'h0,     0, 1, 0, 0,   0, 32'h0,     0, 0, 0);
        step(0, 1, 32'h10,    0, 0, 0, 0,   1, 32'h14,    1, 0, 0);
        step(0, 1, 32'h20,    0, 0, 0, 0,   1, 32'h24,    2, 0, 0);
        step(0, 1, 32'h30,    0, 0, 0, 0,   1, 32'h34,    3, 0, 0);
        step(0, 1, 32'h40,    0, 0, 0, 0,   1, 32'h44,    4, 0, 0);
        step(0, 1, 32'h50,    0, 0, 0, 0,   1, 32'h54,    4, 1, 0);
        step(0, 0, 32'h0,     1, 0, 0, 0,   1, 32'h44,    3, 0, 0);
        step(0, 0, 32'h0,     1, 0, 0, 0,   1, 32'h34,    2, 0, 0);
        step(0, 0, 32'h0,     1, 0, 0, 0,   1, 32'h24,    1, 0, 0);
        step(0, 0, 32'h0,     1, 0, 0, 0,   0, 32'h54,    0, 0, 0);
        // underflow, then push+pop on empty
        step(0, 0, 32'h0,     1, 0, 0, 0,   0, 32'h54,    0, 0, 1);
        step(0, 0, 32'h0,     0, 0, 0, 0,   0, 32'h54,    0, 0, 0);
        step(0, 1, 32'h60,    1, 0, 0, 0,   1, 32'h64,    1, 0, 0);
        // checkpoint repair of a wrong-path pop + overwrite
        step(0, 0, 32'h0,     0, 1, 0, 0,   0, 32'h44,    0, 0, 0);
        step(0, 1, 32'h100,   0, 0, 0, 0,   1, 32'h104,   1, 0, 0);
        step(0, 0, 32'h0,     0, 0, 1, 0,   1, 32'h104,   1, 0, 0);
        step(0, 0, 32'h0,     1, 0, 0, 0,   0, 32'h44,    0, 0, 0);
        step(0, 1, 32'h900,   0, 0, 0, 0,   1, 32'h904,   1, 0, 0);
`ifdef KRV_RAS_CKPT_EN
        step(0, 0, 32'h0,     0, 0, 0, 1,   1, 32'h104,   1, 0, 0);
`else
        step(0, 0, 32'h0,     0, 0, 0, 1,   0, 32'h44,    0, 0, 0);
`endif
        // checkpoint consumed: second restore empties the stack
        step(0, 0, 32'h0,     0, 0, 0, 1,   0, 32'h44,    0, 0, 0);
        // flush beats push; restore without checkpoint empties
        step(0, 1, 32'h700,   0, 0, 0, 0,   1, 32'h704,   1, 0, 0);
        step(0, 1, 32'h800,   0, 1, 0, 0,   0, 32'h44,    0, 0, 0);
        step(0, 1, 32'hA00,   0, 0, 0, 0,   1, 32'hA04,   1, 0, 0);
        step(0, 0, 32'h0,     0, 0, 0, 1,   0, 32'h44,    0, 0, 0);
        // save alongside a push, then restore
        step(0, 1, 32'h100,   0, 0, 0, 0,   1, 32'h104,   1, 0, 0);
        step(0, 1, 32'h200,   0, 0, 1, 0,   1, 32'h204,   2, 0, 0);
        step(0, 1, 32'h300,   0, 0, 0, 0,   1, 32'h304,   3, 0, 0);
`ifdef KRV_RAS_CKPT_EN
        step(0, 0, 32'h0,     0, 0, 0, 1,   1, 32'h204,   2, 0, 0);
`else
        step(0, 0, 32'h0,     0, 0, 0, 1,   0, 32'h44,    0, 0, 0);
`endif
        // reset mid-operation discards the push and clears memory
        step(1, 1, 32'h55,    0, 0, 0, 0,   0, 32'h0,     0, 0, 0);
        step(0, 0, 32'h0,     0, 0, 0, 0,   0, 32'h0,     0, 0, 0);
        @(negedge clk);
        push_vld = 1'b0; pop_vld = 1'b0; flush = 1'b0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk(-1, "queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
